// File: rtl/noc_pkg.sv
// noc_pkg: shared packet field layout and network-interface transmit FSM states.
package noc_pkg;
    localparam int NOC_COL_W  = 4;
    localparam int NOC_ROW_W  = 4;
    localparam int NOC_DATA_W = 8;
    localparam int NOC_PCKT_W = NOC_COL_W + NOC_ROW_W + NOC_DATA_W;
    localparam int DATA_LSB   = 0;
    localparam int ROW_LSB    = NOC_DATA_W;
    localparam int COL_LSB    = NOC_DATA_W + NOC_ROW_W;
    typedef enum logic [1:0] {IDLE, SEND, STALL} ni_state_e;
endpackage

// File: rtl/fifo.sv
// fifo: synchronous FIFO of 2^DEPTH_W entries; a push is ignored when full, a pop when empty.
module fifo #(
    parameter int DEPTH_W = 3,
    parameter int W       = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int DEPTH = 1 << DEPTH_W;
    logic [W-1:0]       mem_q [DEPTH];
    logic [DEPTH_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_W:0]   cnt_q;
    logic               do_push, do_pop;
    assign full_o  = cnt_q[DEPTH_W];
    assign empty_o = cnt_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + DEPTH_W'(do_push);
            rd_ptr_q <= rd_ptr_q + DEPTH_W'(do_pop);
            cnt_q    <= cnt_q + (DEPTH_W+1)'(do_push) - (DEPTH_W+1)'(do_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/ni_tx.sv
// ni_tx: network-interface transmitter; queues core requests and streams packets into the switch resource port.
module ni_tx import noc_pkg::*; #(
    parameter int COL_CORD     = 0,
    parameter int ROW_CORD     = 0,
    parameter int FIFO_DEPTH_W = 3,
    parameter int COL_ADDR_W   = NOC_COL_W,
    parameter int ROW_ADDR_W   = NOC_ROW_W,
    parameter int PCKT_DATA_W  = NOC_DATA_W,
    parameter int PCKT_W       = COL_ADDR_W + ROW_ADDR_W + PCKT_DATA_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [COL_ADDR_W-1:0]  dst_col_i,
    input  logic [ROW_ADDR_W-1:0]  dst_row_i,
    input  logic [PCKT_DATA_W-1:0] data_i,
    output logic                   wr_en_o,
    output logic [PCKT_W-1:0]      pckt_o,
    input  logic                   nxt_fifo_full_i,
    input  logic                   nxt_fifo_overflow_i,
    output logic                   busy_o,
    output logic [15:0]            sent_cnt_o,
    output logic [7:0]             drop_cnt_o,
    output logic                   err_o
);
    ni_state_e         state_q;
    logic              wr_en_q, err_q;
    logic [PCKT_W-1:0] pckt_q, head;
    logic [15:0]       sent_q;
    logic [7:0]        drop_q;
    logic              full, empty, accept, is_self, push, pop;
    assign req_ready_o = !full;
    assign accept      = req_valid_i && !full;
    assign is_self     = dst_col_i == COL_ADDR_W'(COL_CORD) && dst_row_i == ROW_ADDR_W'(ROW_CORD);
    assign push        = accept && !is_self;
    assign pop         = !empty && !nxt_fifo_full_i;
    fifo #(.DEPTH_W(FIFO_DEPTH_W), .W(PCKT_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({dst_col_i, dst_row_i, data_i}),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
            pckt_q  <= '0;
            sent_q  <= '0;
            drop_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, SEND: state_q <= empty ? IDLE : (nxt_fifo_full_i ? STALL : SEND);
                STALL:      state_q <= nxt_fifo_full_i ? STALL : SEND;
                default:    state_q <= IDLE;
            endcase
            wr_en_q <= pop;
            if (pop) pckt_q <= head;
            sent_q  <= sent_q + 16'(pop);
            if (accept && is_self && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            err_q   <= err_q || nxt_fifo_overflow_i;
        end
    end
    assign wr_en_o    = wr_en_q;
    assign pckt_o     = pckt_q;
    assign sent_cnt_o = sent_q;
    assign drop_cnt_o = drop_q;
    assign err_o      = err_q;
    assign busy_o     = !empty || wr_en_q;
endmodule

// File: tb/tb_ni_tx.sv
// tb_ni_tx: table-driven and sequence checks of ni_tx with a packet scoreboard.
module tb_ni_tx;
    import noc_pkg::*;
    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        req_valid_i = 1'b0, nxt_fifo_full_i = 1'b0, nxt_fifo_overflow_i = 1'b0;
    logic [3:0]  dst_col_i = '0, dst_row_i = '0;
    logic [7:0]  data_i = '0;
    logic        req_ready_o, wr_en_o, busy_o, err_o;
    logic [15:0] pckt_o, sent_cnt_o;
    logic [7:0]  drop_cnt_o;
    int          n_cmp = 0, n_bad = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_sent = '0;
    logic [7:0]  exp_drop = '0;

    typedef struct {
        logic [3:0]  c;
        logic [3:0]  r;
        logic [7:0]  d;
        logic [15:0] p;
    } vec_t;
    vec_t vt[5];

    ni_tx dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .dst_col_i(dst_col_i), .dst_row_i(dst_row_i), .data_i(data_i), .wr_en_o(wr_en_o),
        .pckt_o(pckt_o), .nxt_fifo_full_i(nxt_fifo_full_i), .nxt_fifo_overflow_i(nxt_fifo_overflow_i),
        .busy_o(busy_o), .sent_cnt_o(sent_cnt_o), .drop_cnt_o(drop_cnt_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i) begin
            sb.delete();
            exp_sent = '0;
        end else if (wr_en_o) begin
            if (sb.size() == 0) check("unexpected_wr_en", 32'(pckt_o), 32'hDEAD_BEEF);
            else begin
                check("pckt", 32'(pckt_o), 32'(sb.pop_front()));
                exp_sent = exp_sent + 16'd1;
                check("sent_cnt", 32'(sent_cnt_o), 32'(exp_sent));
            end
        end
    end

    task automatic send(input logic [3:0] c, input logic [3:0] r, input logic [7:0] d, input logic [15:0] p);
        logic ok = 1'b0;
        logic rdy;
        req_valid_i = 1'b1;
        dst_col_i = c;
        dst_row_i = r;
        data_i = d;
        for (int k = 0; k < 64 && !ok; k++) begin
            rdy = req_ready_o;
            @(posedge clk_i);
            ok = rdy;
            #1;
        end
        if (!ok) check("accept_timeout", 32'(ok), 32'd1);
        else if (c == 4'd0 && r == 4'd0) begin
            if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
        end else sb.push_back(p);
    endtask

    task automatic drain();
        for (int k = 0; k < 64 && sb.size() != 0; k++) begin
            @(posedge clk_i);
            #1;
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic tick_check(input string nm, input int n, input logic exp_wr);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i);
            #1;
            check(nm, 32'(wr_en_o), 32'(exp_wr));
        end
    endtask

    initial begin
        vt[0] = '{4'h2, 4'h1, 8'hA5, 16'h21A5};
        vt[1] = '{4'hF, 4'hF, 8'h00, 16'hFF00};
        vt[2] = '{4'h3, 4'h0, 8'h5A, 16'h305A};
        vt[3] = '{4'h0, 4'h7, 8'hFF, 16'h07FF};
        vt[4] = '{4'h0, 4'h0, 8'h11, 16'h0000};
        #1;
        check("rst_wr_en", 32'(wr_en_o), 0);
        check("rst_pckt", 32'(pckt_o), 0);
        check("rst_sent", 32'(sent_cnt_o), 0);
        check("rst_drop", 32'(drop_cnt_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_ready", 32'(req_ready_o), 1);
        #10 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        // single request: pulse appears exactly one cycle after the accepting edge
        send(4'h2, 4'h1, 8'hA5, 16'h21A5);
        req_valid_i = 1'b0;
        check("lat_early", 32'(wr_en_o), 0);
        @(posedge clk_i);
        #1;
        check("lat_wr_en", 32'(wr_en_o), 1);
        check("lat_pckt", 32'(pckt_o), 32'h21A5);
        check("lat_sent", 32'(sent_cnt_o), 1);
        drain();
        check("idle_busy", 32'(busy_o), 0);
        for (int i = 0; i < 5; i++) begin
            send(vt[i].c, vt[i].r, vt[i].d, vt[i].p);
            req_valid_i = 1'b0;
            drain();
            check("tbl_drop", 32'(drop_cnt_o), 32'(exp_drop));
            check("tbl_ready", 32'(req_ready_o), 1);
            check("tbl_busy", 32'(busy_o), 0);
        end
        // back-pressure: three queued packets held, then released back-to-back
        nxt_fifo_full_i = 1'b1;
        send(4'h1, 4'h2, 8'h11, 16'h1211);
        send(4'h3, 4'h4, 8'h22, 16'h3422);
        send(4'h5, 4'h6, 8'h33, 16'h5633);
        req_valid_i = 1'b0;
        tick_check("bp_hold", 4, 1'b0);
        check("bp_state", 32'(dut.state_q), 32'(STALL));
        check("bp_busy", 32'(busy_o), 1);
        nxt_fifo_full_i = 1'b0;
        tick_check("bp_burst", 3, 1'b1);
        tick_check("bp_end", 1, 1'b0);
        drain();
        // fill: eight accepts fill the queue; the ninth waits and is not lost
        nxt_fifo_full_i = 1'b1;
        for (int i = 0; i < 8; i++)
            send(4'(i + 1), 4'h2, 8'(i * 3), {4'(i + 1), 4'h2, 8'(i * 3)});
        check("fill_ready", 32'(req_ready_o), 0);
        dst_col_i = 4'h9;
        dst_row_i = 4'h9;
        data_i = 8'h99;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #1;
            check("fill_hold_ready", 32'(req_ready_o), 0);
        end
        nxt_fifo_full_i = 1'b0;
        send(4'h9, 4'h9, 8'h99, 16'h9999);
        req_valid_i = 1'b0;
        drain();
        // self-address drops, including saturation of the drop counter
        send(4'h0, 4'h0, 8'h42, 16'h0000);
        req_valid_i = 1'b0;
        check("self_ready", 32'(req_ready_o), 1);
        tick_check("self_no_wr", 2, 1'b0);
        check("self_drop", 32'(drop_cnt_o), 32'(exp_drop));
        for (int i = 0; i < 260; i++) send(4'h0, 4'h0, 8'(i), 16'h0000);
        req_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("drop_sat", 32'(drop_cnt_o), 32'hFF);
        // sticky error, then asynchronous reset in the middle of a burst
        nxt_fifo_overflow_i = 1'b1;
        @(posedge clk_i);
        #1;
        nxt_fifo_overflow_i = 1'b0;
        check("err_set", 32'(err_o), 1);
        repeat (3) @(posedge clk_i);
        #1;
        check("err_sticky", 32'(err_o), 1);
        nxt_fifo_full_i = 1'b1;
        for (int i = 0; i < 5; i++) send(4'hA, 4'(i), 8'(i), {4'hA, 4'(i), 8'(i)});
        req_valid_i = 1'b0;
        nxt_fifo_full_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("pre_rst_wr_en", 32'(wr_en_o), 1);
        #1 rst_i = 1'b1;
        #1;
        check("arst_wr_en", 32'(wr_en_o), 0);
        check("arst_err", 32'(err_o), 0);
        check("arst_busy", 32'(busy_o), 0);
        check("arst_ready", 32'(req_ready_o), 1);
        check("arst_sent", 32'(sent_cnt_o), 0);
        check("arst_drop", 32'(drop_cnt_o), 0);
        check("arst_pckt", 32'(pckt_o), 0);
        exp_drop = '0;
        @(negedge clk_i);
        #1 rst_i = 1'b0;
        tick_check("post_rst_quiet", 6, 1'b0);
        // sent counter wrap: 65535 sends, then one more wraps to zero
        for (int i = 0; i < 65535; i++)
            send(4'(1 + i % 15), 4'(i), 8'(i >> 4), {4'(1 + i % 15), 4'(i), 8'(i >> 4)});
        req_valid_i = 1'b0;
        drain();
        check("wrap_pre", 32'(sent_cnt_o), 32'hFFFF);
        send(4'h7, 4'h7, 8'h77, 16'h7777);
        req_valid_i = 1'b0;
        drain();
        check("wrap_zero", 32'(sent_cnt_o), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
